mem_write_monitor: RTL and testbench
====================================

MEM_WRITE_MONITOR -- requirements
Module: mem_write_monitor

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- WIDTH, 32, address/data width.
- DEPTH, 4, expected-write table entries.
- TIMEOUT, 150, run-cycle limit.
- STRICT, 0, unexpected-address writes fail when 1.
REQ-002 Ports (name direction width meaning) SHALL be:
- clk in 1: single clock, rising edge.
- reset in 1: asynchronous, active-low.
- memwrite in 1: observed store strobe.
- dataadr in WIDTH: store address.
- writedata in WIDTH: store data.
- cfg_we in 1: table write strobe.
- cfg_idx in clog2(DEPTH): table index.
- cfg_addr in WIDTH: expected address.
- cfg_data in WIDTH: expected data.
- exp_count in clog2(DEPTH)+1: entries to check, 1..DEPTH.
- start in 1: arm the monitor.
- busy out 1: high in RUN.
- done out 1: high in PASS or FAIL.
- pass out 1: high in PASS.
- fail_code out 2: 0 none, 1 data mismatch, 2 unexpected address, 3 timeout.
- match_count out clog2(DEPTH)+1: entries matched so far.
- fail_addr out WIDTH: dataadr at failure.
- fail_data out WIDTH: writedata at failure.
- cycle_count out 32: cycles spent in RUN.

Function
REQ-003 FSM SHALL have states IDLE, RUN, PASS, FAIL; all outputs registered.
REQ-004 cfg_we SHALL write the table entry on the clock edge in IDLE, PASS or FAIL; in RUN it SHALL be ignored.
REQ-005 start in any state other than RUN SHALL, next cycle, enter RUN and:
- latch exp_count;
- clear match_count, cycle_count, fail_code, fail_addr, fail_data.
REQ-006 start while in RUN SHALL be ignored.
REQ-007 exp_count of 0 or greater than DEPTH at start SHALL be clamped to DEPTH.
REQ-008 In RUN, cycle_count SHALL increment by 1 every cycle and saturate at all-ones.
REQ-009 Checking in RUN SHALL be ordered: only entry match_count is compared on each memwrite cycle.
REQ-010 When memwrite is high, dataadr equals the expected address and writedata equals the expected data, match_count SHALL increment.
REQ-011 When that match is the latched exp_count-th match, the FSM SHALL enter PASS on the same edge.
REQ-012 When memwrite is high and the address matches but the data differs, the FSM SHALL enter FAIL with fail_code 1 and capture the address and data.
REQ-013 When memwrite is high and the address differs from the expected address:
- STRICT=1: the FSM SHALL enter FAIL with fail_code 2 and capture the address and data;
- STRICT=0: the write SHALL be ignored.
REQ-014 Timeout: on the cycle where cycle_count equals TIMEOUT-1 with no completing match, the FSM SHALL enter FAIL with fail_code 3; fail_addr and fail_data SHALL be 0.
REQ-015 Priority on the same cycle SHALL be: completing match > mismatch or unexpected address > timeout.
REQ-016 memwrite seen in IDLE, PASS or FAIL SHALL be ignored.
REQ-017 PASS and FAIL SHALL hold all outputs until the next start or reset.
REQ-018 Latency SHALL be exactly one cycle: outputs reflect an event at the first rising edge after the event is sampled.

Reset
REQ-019 reset low SHALL, asynchronously, force:
- state IDLE;
- busy, done, pass, fail_code, match_count, fail_addr, fail_data and cycle_count all 0.
REQ-020 Table contents SHALL be cleared to 0 by reset.
REQ-021 reset asserted mid-RUN SHALL abort the run; a new start is then required.

Structure
REQ-022 A shared package SHALL hold:
- the state encoding (IDLE=0, RUN=1, PASS=2, FAIL=3);
- the fail_code constants;
- the default TIMEOUT.
REQ-023 The expected-write table SHALL be one sub-module, mwm_table: DEPTH x 2*WIDTH registers, one write port, one combinational read port indexed by match_count.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Table {(40,49)}, exp_count 1, start, then memwrite dataadr=40 writedata=49 -> next cycle pass=1, done=1, match_count=1.
- Table {(80,7),(84,7)}, STRICT=0, writes (84,9),(80,7),(84,7) -> pass=1, match_count=2; the first write is ignored.
- Same table, STRICT=1, first write (84,9) -> fail_code=2, fail_addr=84, fail_data=9.
- Table {(40,49)}, write (40,50) -> fail_code=1, fail_addr=40, fail_data=50, busy=0.
- No matching writes, TIMEOUT=150 -> fail_code=3 exactly 150 cycles after entering RUN; cycle_count=150.
- Completing match on the timeout cycle -> pass=1. Separately, reset low mid-RUN -> all outputs 0, and a following start re-arms with counters cleared.

Source files
------------

// File: rtl/mem_write_monitor_pkg.sv
// Shared definitions for the memory-write monitor: FSM state encoding,
// failure codes and the default run-cycle limit.
package mem_write_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_DATA    = 2'd1,
        FC_ADDR    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_e;

    localparam int DEFAULT_TIMEOUT = 150;

endpackage : mem_write_monitor_pkg

// File: rtl/mwm_table.sv
// Expected-write table: DEPTH entries of {address, data}, one synchronous
// write port and one combinational read port.
module mwm_table #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [WIDTH-1:0] rd_addr_o,
    output logic [WIDTH-1:0] rd_data_o
);

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t table_q [DEPTH];

    // NOTE: the table is small register storage that must read back as zero
    // after reset, so it is reset like any other flop rather than left as RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (we_i) begin
            table_q[wr_idx_i] <= '{addr: wr_addr_i, data: wr_data_i};
        end
    end

    assign rd_addr_o = table_q[rd_idx_i].addr;
    assign rd_data_o = table_q[rd_idx_i].data;

endmodule : mwm_table

// File: rtl/mem_write_monitor.sv
// Watches a store bus for an ordered list of expected (address, data) writes
// and reports pass, mismatch, unexpected address or timeout.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter bit STRICT  = 1'b0,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] dataadr,
    input  logic [WIDTH-1:0] writedata,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [WIDTH-1:0] cfg_addr,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic [CNT_W-1:0] exp_count,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] match_count,
    output logic [WIDTH-1:0] fail_addr,
    output logic [WIDTH-1:0] fail_data,
    output logic [31:0]      cycle_count
);

    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_e           state_q;
    fail_code_e       fail_code_q;
    logic [CNT_W-1:0] exp_q;
    logic [CNT_W-1:0] match_count_q;
    logic [WIDTH-1:0] fail_addr_q;
    logic [WIDTH-1:0] fail_data_q;
    logic [31:0]      cycle_count_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic [WIDTH-1:0] exp_addr;
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] exp_count_d;
    logic [CNT_W-1:0] match_count_d;
    logic             addr_eq;
    logic             data_eq;
    logic             completing;
    logic             timed_out;

    mwm_table #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .we_i      (cfg_we && (state_q != ST_RUN)),
        .wr_idx_i  (cfg_idx),
        .wr_addr_i (cfg_addr),
        .wr_data_i (cfg_data),
        .rd_idx_i  (match_count_q[IDX_W-1:0]),
        .rd_addr_o (exp_addr),
        .rd_data_o (exp_data)
    );

    assign exp_count_d   = ((exp_count == '0) || (exp_count > DEPTH_C)) ? DEPTH_C : exp_count;
    assign match_count_d = match_count_q + CNT_W'(1);
    assign addr_eq       = memwrite && (dataadr == exp_addr);
    assign data_eq       = (writedata == exp_data);
    assign completing    = addr_eq && data_eq && (match_count_d == exp_q);
    assign timed_out     = (cycle_count_q == TIMEOUT_LAST);

    // NOTE: every state and output register is assigned with <= so all of
    // them update together from the values sampled before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            fail_code_q   <= FC_NONE;
            exp_q         <= '0;
            match_count_q <= '0;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
            cycle_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cycle_count_q != '1) begin
                        cycle_count_q <= cycle_count_q + 32'd1;
                    end
                    if (addr_eq && data_eq) begin
                        match_count_q <= match_count_d;
                    end
                    if (completing) begin
                        state_q <= ST_PASS;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end else if (addr_eq && !data_eq) begin
                        state_q     <= ST_FAIL;
                        fail_code_q <= FC_DATA;
                        fail_addr_q <= dataadr;
                        fail_data_q <= writedata;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (STRICT && memwrite && !addr_eq) begin
                        state_q     <= ST_FAIL;
                        fail_code_q <= FC_ADDR;
                        fail_addr_q <= dataadr;
                        fail_data_q <= writedata;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (timed_out) begin
                        // Capture registers were cleared at start, so they read 0 here.
                        state_q     <= ST_FAIL;
                        fail_code_q <= FC_TIMEOUT;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_q       <= ST_RUN;
                        exp_q         <= exp_count_d;
                        fail_code_q   <= FC_NONE;
                        match_count_q <= '0;
                        fail_addr_q   <= '0;
                        fail_data_q   <= '0;
                        cycle_count_q <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        pass_q        <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign match_count = match_count_q;
    assign fail_addr   = fail_addr_q;
    assign fail_data   = fail_data_q;
    assign cycle_count = cycle_count_q;

endmodule : mem_write_monitor

// File: tb/tb_mem_write_monitor.sv
// Directed bench for mem_write_monitor: a lenient and a strict instance share
// one stimulus stream; expected values are worked out by hand.
module tb_mem_write_monitor;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic [2:0]  exp_count;
    logic        start;

    logic        busy,   s_busy;
    logic        done,   s_done;
    logic        pass,   s_pass;
    logic [1:0]  fail_code, s_fail_code;
    logic [2:0]  match_count, s_match_count;
    logic [31:0] fail_addr, s_fail_addr;
    logic [31:0] fail_data, s_fail_data;
    logic [31:0] cycle_count, s_cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_write_monitor #(.WIDTH(WIDTH), .DEPTH(4), .TIMEOUT(150), .STRICT(1'b0)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .exp_count   (exp_count),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .match_count (match_count),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data),
        .cycle_count (cycle_count)
    );

    mem_write_monitor #(.WIDTH(WIDTH), .DEPTH(4), .TIMEOUT(150), .STRICT(1'b1)) u_dut_strict (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .exp_count   (exp_count),
        .start       (start),
        .busy        (s_busy),
        .done        (s_done),
        .pass        (s_pass),
        .fail_code   (s_fail_code),
        .match_count (s_match_count),
        .fail_addr   (s_fail_addr),
        .fail_data   (s_fail_data),
        .cycle_count (s_cycle_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_addr = addr;
        cfg_data = data;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic arm(input logic [2:0] cnt);
        start     = 1'b1;
        exp_count = cnt;
        step();
        start     = 1'b0;
    endtask

    task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        step();
        memwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
        exp_count = '0; start = 1'b0;
        step(2);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_code", fail_code, 0);
        check("rst_match", match_count, 0);
        check("rst_cycles", cycle_count, 0);
        reset = 1'b1;
        step();

        // Single-entry pass
        cfg_write(2'd0, 32'd40, 32'd49);
        arm(3'd1);
        check("s1_busy", busy, 1);
        check("s1_cycles0", cycle_count, 0);
        mem_wr(32'd40, 32'd49);
        check("s1_pass", pass, 1);
        check("s1_done", done, 1);
        check("s1_busy_lo", busy, 0);
        check("s1_match", match_count, 1);
        check("s1_cycles", cycle_count, 1);
        memwrite = 1'b1; dataadr = 32'd40; writedata = 32'd50;
        step(2);
        memwrite = 1'b0;
        check("s1_hold_pass", pass, 1);
        check("s1_hold_code", fail_code, 0);

        // Two entries: lenient ignores the stray write, strict fails on it
        cfg_write(2'd0, 32'd80, 32'd7);
        cfg_write(2'd1, 32'd84, 32'd7);
        arm(3'd2);
        mem_wr(32'd84, 32'd9);
        check("s2_busy", busy, 1);
        check("s2_match0", match_count, 0);
        check("s2s_code", s_fail_code, 2);
        check("s2s_addr", s_fail_addr, 84);
        check("s2s_data", s_fail_data, 9);
        check("s2s_done", s_done, 1);
        mem_wr(32'd80, 32'd7);
        check("s2_match1", match_count, 1);
        check("s2_busy1", busy, 1);
        mem_wr(32'd84, 32'd7);
        check("s2_pass", pass, 1);
        check("s2_match2", match_count, 2);
        check("s2s_hold_code", s_fail_code, 2);
        check("s2s_hold_match", s_match_count, 0);

        // Data mismatch
        cfg_write(2'd0, 32'd40, 32'd49);
        arm(3'd1);
        mem_wr(32'd40, 32'd50);
        check("s3_code", fail_code, 1);
        check("s3_addr", fail_addr, 40);
        check("s3_data", fail_data, 50);
        check("s3_busy", busy, 0);
        check("s3_done", done, 1);
        check("s3_pass", pass, 0);

        // Timeout, with a start pulse mid-run that must be ignored
        arm(3'd1);
        check("s4_cleared_addr", fail_addr, 0);
        check("s4_cleared_code", fail_code, 0);
        step(10);
        start = 1'b1;
        step();
        start = 1'b0;
        check("s4_cycles11", cycle_count, 11);
        step(138);
        check("s4_busy149", busy, 1);
        check("s4_cycles149", cycle_count, 149);
        step();
        check("s4_code", fail_code, 3);
        check("s4_cycles", cycle_count, 150);
        check("s4_addr", fail_addr, 0);
        check("s4_data", fail_data, 0);
        check("s4_busy", busy, 0);
        step(3);
        check("s4_hold_cycles", cycle_count, 150);

        // Completing match lands on the timeout cycle
        arm(3'd1);
        step(149);
        check("s5_cycles149", cycle_count, 149);
        mem_wr(32'd40, 32'd49);
        check("s5_pass", pass, 1);
        check("s5_code", fail_code, 0);
        check("s5_cycles", cycle_count, 150);

        // exp_count 0 clamps to DEPTH
        cfg_write(2'd0, 32'd100, 32'd1);
        cfg_write(2'd1, 32'd104, 32'd2);
        cfg_write(2'd2, 32'd108, 32'd3);
        cfg_write(2'd3, 32'd112, 32'd4);
        arm(3'd0);
        mem_wr(32'd100, 32'd1);
        mem_wr(32'd104, 32'd2);
        mem_wr(32'd108, 32'd3);
        check("s6_busy3", busy, 1);
        check("s6_match3", match_count, 3);
        mem_wr(32'd112, 32'd4);
        check("s6_pass", pass, 1);
        check("s6_match4", match_count, 4);

        // Reset mid-run, then re-arm against a cleared table
        arm(3'd1);
        step(5);
        reset = 1'b0;
        #1;
        check("s7_busy", busy, 0);
        check("s7_cycles", cycle_count, 0);
        check("s7_done", done, 0);
        check("s7_match", match_count, 0);
        step(2);
        check("s7_still_idle", busy, 0);
        reset = 1'b1;
        step();
        arm(3'd1);
        check("s7_rearm_busy", busy, 1);
        check("s7_rearm_cycles", cycle_count, 0);
        cfg_write(2'd0, 32'd5, 32'd5);
        mem_wr(32'd0, 32'd0);
        check("s7_pass_cleared", pass, 1);
        check("s7_match", match_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_write_monitor
